csr_requester: RTL and testbench
================================

Name: csr_requester

Overview:
- Pipeline-side initiator for the CSR instruction interface that `csr_file` responds to.
- Accepts one decoded SYSTEM instruction plus its rs1 operand, checks legality, and issues a single-cycle CSR access.
- Captures the returned read data and produces a one-cycle register-file writeback or an illegal-instruction pulse.
- Sits between decode/operand-read and the integer writeback mux.

Parameters:
- ADDR_CYCLE, 12'hC00, cycle counter low word (read-only)
- ADDR_CYCLEH, 12'hC80, cycle counter high word (read-only)
- ADDR_DSPMODE, 12'h800, DSP mode register (read/write)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered by decode
- instr_ready  out  1  block can accept an instruction
- instr  in  32  raw instruction word
- rs1_data  in  32  rs1 register value, sampled with instr
- flush  in  1  kill any in-flight operation
- csr_valid  out  1  CSR access strobe to responder
- csr_addr  out  12  instr[31:20]
- csr_funct3  out  3  instr[14:12]
- csr_rs1  out  5  instr[19:15]
- csr_rd  out  5  instr[11:7]
- csr_wdata  out  32  latched rs1_data
- csr_zimm  out  5  instr[19:15]
- csr_rdata  in  32  responder read data, combinational in the csr_valid cycle
- wb_valid  out  1  register writeback strobe
- wb_rd  out  5  writeback destination
- wb_data  out  32  writeback value
- illegal  out  1  illegal CSR instruction pulse
- busy  out  1  state != IDLE

Behaviour:
- State machine: IDLE, ISSUE, WB.
- Reset (async, rst=1) forces IDLE and clears all latched fields and the captured read data. Reset-state outputs: instr_ready=1, csr_valid=0, wb_valid=0, illegal=0, busy=0, all data outputs 0.
- Reset asserted mid-operation aborts the operation; no csr_valid or wb_valid is produced for it.
- instr_ready=1 only in IDLE and only when flush=0. Handshake is instr_valid & instr_ready.
- IDLE: on handshake, latch instr and rs1_data, compute the illegal flag, then go to ISSUE.
- Write intent:
  - funct3 001/101: always write.
  - funct3 010/011: write when the rs1 field != 0.
  - funct3 110/111: write when zimm != 0.
- Illegal when any of the following holds:
  - instr[6:0] != 7'b1110011;
  - funct3 is 000 or 100;
  - addr is not one of the three parameter addresses;
  - addr[11:10]==2'b11 with write intent.
- ISSUE (exactly 1 cycle):
  - csr_valid = !illegal & !flush; csr_* outputs are driven from the latched fields.
  - Register csr_rdata into the capture register; the capture value is don't-care if illegal.
  - Go to WB, or to IDLE if flush.
- csr_* data outputs hold latched values in every state; csr_valid is the only qualifier.
- WB (exactly 1 cycle): go to IDLE.
  - wb_valid = !illegal & (rd!=0) & !flush.
  - wb_rd = latched rd; wb_data = captured rdata.
  - illegal = latched illegal & !flush.
- Latency: accept at cycle N, csr_valid at N+1, wb_valid/illegal at N+2. Next accept at N+3 at the earliest (max throughput 1 per 3 cycles).
- Because ISSUE is a single cycle, the responder's DSP-mode update lands before any following CSR read, so back-to-back write then read returns the new value.
- flush has priority over every transition: next state is IDLE, and outputs are gated in the same cycle.
- flush while in IDLE blocks acceptance for that cycle.

Test Plan:
- Reset, hold instr_valid=0 -> instr_ready=1, busy=0, csr_valid/wb_valid/illegal=0.
- instr=0xC00022F3 (csrrs x5,cycle,x0), responder returns 0x00000123 -> csr_valid at N+1 with addr=C00, funct3=010, rs1=0; wb_valid at N+2 with rd=5, data=0x123; no write intent.
- instr=0x8001D073 (csrrwi x0,0x800,3) then csrrs x6,0x800,x0 -> first op: csr_valid=1, zimm=3, wb_valid=0 (rd=0); second op: wb_data=0x00000003.
- instr=0xC80110F3 (csrrw x1,cycleh,x2) -> csr_valid stays 0, illegal=1 at N+2, wb_valid=0.
- instr=0x00000013 (addi) -> illegal pulse at N+2, no csr_valid.
- Flush asserted in the ISSUE cycle of a legal op -> csr_valid=0 that cycle, no wb_valid, IDLE next, instr_ready=1 the following cycle. Repeat with rst pulsed during WB -> wb_valid drops immediately.

Source files
------------

// File: rtl/csr_requester_if.sv
// csr_requester_if: decode-side instruction handshake, CSR access bus and writeback outputs of csr_requester.
interface csr_requester_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic        flush;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [4:0]  csr_rs1;
  logic [4:0]  csr_rd;
  logic [31:0] csr_wdata;
  logic [4:0]  csr_zimm;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;
  modport master (
    output instr_valid, instr, rs1_data, flush, csr_rdata,
    input  instr_ready, csr_valid, csr_addr, csr_funct3, csr_rs1, csr_rd, csr_wdata, csr_zimm,
           wb_valid, wb_rd, wb_data, illegal, busy
  );
  modport slave (
    input  instr_valid, instr, rs1_data, flush, csr_rdata,
    output instr_ready, csr_valid, csr_addr, csr_funct3, csr_rs1, csr_rd, csr_wdata, csr_zimm,
           wb_valid, wb_rd, wb_data, illegal, busy
  );
endinterface

// File: rtl/csr_requester.sv
// csr_requester: accepts one SYSTEM instruction, issues a single-cycle CSR access, then writes back or flags illegal.
module csr_requester #(
  parameter logic [11:0] ADDR_CYCLE   = 12'hC00,
  parameter logic [11:0] ADDR_CYCLEH  = 12'hC80,
  parameter logic [11:0] ADDR_DSPMODE = 12'h800
) (
  input logic           clk,
  input logic           rst,
  csr_requester_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  state_t      r_state;
  logic [24:0] r_fields;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_illegal;
  logic [11:0] w_addr;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic        w_write;
  logic        w_known;
  logic        w_illegal;
  logic        w_accept;
  assign w_addr   = bus.instr[31:20];
  assign w_f3     = bus.instr[14:12];
  assign w_rs1    = bus.instr[19:15];
  // rs1 field and zimm share bits [19:15], so set/clear forms test the same field
  assign w_write  = (w_f3[1:0] == 2'b01) || (w_f3[1] && (w_rs1 != 5'd0));
  assign w_known  = (w_addr == ADDR_CYCLE) || (w_addr == ADDR_CYCLEH) || (w_addr == ADDR_DSPMODE);
  assign w_illegal = (bus.instr[6:0] != 7'b1110011) || (w_f3[1:0] == 2'b00) || !w_known ||
                     ((w_addr[11:10] == 2'b11) && w_write);
  assign w_accept = bus.instr_valid && bus.instr_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_fields  <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fields  <= bus.instr[31:7];
        r_wdata   <= bus.rs1_data;
        r_illegal <= w_illegal;
      end
      if (r_state == ISSUE) r_rdata <= bus.csr_rdata;
      r_state <= bus.flush ? IDLE :
                 (r_state == IDLE)  ? (w_accept ? ISSUE : IDLE) :
                 (r_state == ISSUE) ? WB : IDLE;
    end
  end
  assign bus.instr_ready = (r_state == IDLE) && !bus.flush;
  assign bus.busy        = (r_state != IDLE);
  assign bus.csr_valid   = (r_state == ISSUE) && !r_illegal && !bus.flush;
  assign bus.csr_addr    = r_fields[24:13];
  assign bus.csr_rs1     = r_fields[12:8];
  assign bus.csr_zimm    = r_fields[12:8];
  assign bus.csr_funct3  = r_fields[7:5];
  assign bus.csr_rd      = r_fields[4:0];
  assign bus.csr_wdata   = r_wdata;
  assign bus.wb_valid    = (r_state == WB) && !r_illegal && (r_fields[4:0] != 5'd0) && !bus.flush;
  assign bus.wb_rd       = r_fields[4:0];
  assign bus.wb_data     = r_rdata;
  assign bus.illegal     = (r_state == WB) && r_illegal && !bus.flush;
endmodule

// File: tb/tb_csr_requester.sv
// tb_csr_requester: table-driven checks of csr_requester plus flush/reset corner sequences.
module tb_csr_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] cur_rdata = '0;
  logic [31:0] dsp = '0;
  csr_requester_if bus ();
  csr_requester dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // minimal responder: DSP mode register readable/writable, other addresses return the vector's value
  assign bus.csr_rdata = (bus.csr_addr == 12'h800) ? dsp : cur_rdata;
  always @(posedge clk)
    if (bus.csr_valid && bus.csr_addr == 12'h800)
      if (bus.csr_funct3 == 3'b101) dsp <= {27'd0, bus.csr_zimm};
      else if (bus.csr_funct3 == 3'b001) dsp <= bus.csr_wdata;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rdata;
    logic        exp_csr;
    logic        exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;
  vec_t vecs [10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v);
    @(negedge clk);
    bus.instr = v.instr;
    bus.rs1_data = v.rs1;
    bus.instr_valid = 1'b1;
    cur_rdata = v.rdata;
    #1 check("ready_before", {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    check("csr_valid", {31'd0, bus.csr_valid}, {31'd0, v.exp_csr});
    check("csr_addr", {20'd0, bus.csr_addr}, {20'd0, v.instr[31:20]});
    check("csr_funct3", {29'd0, bus.csr_funct3}, {29'd0, v.instr[14:12]});
    check("csr_zimm", {27'd0, bus.csr_zimm}, {27'd0, v.instr[19:15]});
    check("csr_wdata", bus.csr_wdata, v.rs1);
    check("busy_issue", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, v.exp_wb});
    check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, v.exp_rd});
    if (v.exp_wb) check("wb_data", bus.wb_data, v.exp_data);
    check("illegal", {31'd0, bus.illegal}, {31'd0, v.exp_ill});
    check("csr_valid_wb", {31'd0, bus.csr_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_wb", {31'd0, bus.wb_valid | bus.illegal}, 32'd0);
  endtask
  initial begin
    //          instr         rs1           rdata         csr  wb   rd  data          ill
    vecs[0] = '{32'hC00022F3, 32'h0,        32'h00000123, 1'b1, 1'b1, 5'd5, 32'h00000123, 1'b0};
    vecs[1] = '{32'h8001D073, 32'h0,        32'h0,        1'b1, 1'b0, 5'd0, 32'h0,        1'b0};
    vecs[2] = '{32'h80002373, 32'h0,        32'h0,        1'b1, 1'b1, 5'd6, 32'h00000003, 1'b0};
    vecs[3] = '{32'hC80110F3, 32'hDEAD,     32'h55,       1'b0, 1'b0, 5'd1, 32'h0,        1'b1};
    vecs[4] = '{32'h00000013, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h0,        1'b1};
    vecs[5] = '{32'h800000F3, 32'h0,        32'h0,        1'b0, 1'b0, 5'd1, 32'h0,        1'b1};
    vecs[6] = '{32'h801020F3, 32'h0,        32'h0,        1'b0, 1'b0, 5'd1, 32'h0,        1'b1};
    vecs[7] = '{32'hC00120F3, 32'h7,        32'h99,       1'b0, 1'b0, 5'd1, 32'h0,        1'b1};
    vecs[8] = '{32'hC80030F3, 32'h0,        32'hABCD0001, 1'b1, 1'b1, 5'd1, 32'hABCD0001, 1'b0};
    vecs[9] = '{32'h800090F3, 32'h12345678, 32'h0,        1'b1, 1'b1, 5'd1, 32'h00000003, 1'b0};
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.rs1_data = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_strobes", {29'd0, bus.csr_valid, bus.wb_valid, bus.illegal}, 32'd0);
    check("rst_addr", {20'd0, bus.csr_addr}, 32'd0);
    check("rst_wbdata", bus.wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_op(vecs[i]);
    check("dsp_written_by_csrrw", dsp, 32'h12345678);
    // flush in IDLE blocks acceptance
    @(negedge clk);
    bus.instr = 32'hC00022F3;
    bus.instr_valid = 1'b1;
    bus.flush = 1'b1;
    #1 check("flush_idle_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.flush = 1'b0;
    // flush during ISSUE of a legal op
    @(negedge clk);
    cur_rdata = 32'h777;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    check("pre_flush_csr_valid", {31'd0, bus.csr_valid}, 32'd1);
    bus.flush = 1'b1;
    #1 check("flush_issue_csr_valid", {31'd0, bus.csr_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    check("flush_next_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_next_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("flush_next_ready", {31'd0, bus.instr_ready}, 32'd1);
    // reset pulsed during WB
    @(negedge clk);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_wb_ready", {31'd0, bus.instr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
